// File: rtl/drive_seq.sv
// drive_seq: command sequencer feeding the dual-channel PWM drive block.
// Queues timed speed commands, slews both channels toward each command's
// targets, holds them for the commanded number of ticks, and ramps to a
// controlled stop when the queue empties or on abort.
// Build option: define DRIVE_SEQ_RAMP_EN for slew-limited ramping; without it
// speeds jump straight to their targets (and straight to zero on stop).
module drive_seq #(
   parameter int DEPTH    = 4,
   parameter int RAMP_DIV = 1000,
   parameter int TICK_DIV = 1000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [5:0]               cmd_speed_0,
   input  logic [5:0]               cmd_speed_1,
   input  logic [15:0]              cmd_hold,
   input  logic                     abort,
   output logic [5:0]               speed_0,
   output logic [5:0]               speed_1,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, RAMP, HOLD, STOP} state_t;

   state_t        state;
   logic [27:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [27:0]   head;
   logic          push;
   logic          pop;
   logic [5:0]    tgt_0;
   logic [5:0]    tgt_1;
   logic [15:0]   hold_cnt;
   logic [TW-1:0] tick_pre;

   // A full queue never accepts, even if the head is popped this cycle.
   assign cmd_ready = rst_n && (fifo_count < CW'(DEPTH)) && !abort;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == LOAD) && !abort;
   assign head      = mem[rd_ptr];

`ifdef DRIVE_SEQ_RAMP_EN
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [RW-1:0] ramp_pre;
   logic          ramp_wrap;
   logic          at_tgt;

   assign ramp_wrap = (ramp_pre == RW'(RAMP_DIV - 1));
   assign at_tgt    = (speed_0 == tgt_0) && (speed_1 == tgt_1);

   // One unit toward the target; cannot leave 0..63 since the target is in range.
   function automatic logic [5:0] step_toward(input logic [5:0] cur, input logic [5:0] tgt);
      if (cur < tgt) return cur + 6'd1;
      else if (cur > tgt) return cur - 6'd1;
      else return cur;
   endfunction
`else
   // The slew divider has no effect when speeds jump straight to target.
   logic [31:0] unused_ramp_div;
   assign unused_ramp_div = RAMP_DIV;
`endif

   // Queue pointers and occupancy; abort flushes by aligning the pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (abort) begin
         rd_ptr     <= wr_ptr;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Command storage: payload only, no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_speed_0, cmd_speed_1, cmd_hold};
   end

   // Sequencer: load, slew, hold, stop, with abort overriding all but reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         speed_0  <= '0;
         speed_1  <= '0;
         tgt_0    <= '0;
         tgt_1    <= '0;
         hold_cnt <= '0;
         tick_pre <= '0;
`ifdef DRIVE_SEQ_RAMP_EN
         ramp_pre <= '0;
`endif
      end else if (abort && (state == LOAD || state == RAMP || state == HOLD)) begin
         state <= STOP;
         tgt_0 <= '0;
         tgt_1 <= '0;
`ifdef DRIVE_SEQ_RAMP_EN
         ramp_pre <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fifo_count != '0 && !abort) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               tgt_0    <= head[27:22];
               tgt_1    <= head[21:16];
               hold_cnt <= head[15:0];
               state    <= RAMP;
`ifdef DRIVE_SEQ_RAMP_EN
               ramp_pre <= '0;
`endif
            end
            RAMP: begin
`ifdef DRIVE_SEQ_RAMP_EN
               if (at_tgt) begin
                  state    <= HOLD;
                  tick_pre <= '0;
               end else if (ramp_wrap) begin
                  ramp_pre <= '0;
                  speed_0  <= step_toward(speed_0, tgt_0);
                  speed_1  <= step_toward(speed_1, tgt_1);
               end else begin
                  ramp_pre <= ramp_pre + 1'b1;
               end
`else
               speed_0  <= tgt_0;
               speed_1  <= tgt_1;
               state    <= HOLD;
               tick_pre <= '0;
`endif
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  if (fifo_count != '0) begin
                     state <= LOAD;
                  end else begin
                     state <= STOP;
                     tgt_0 <= '0;
                     tgt_1 <= '0;
`ifdef DRIVE_SEQ_RAMP_EN
                     ramp_pre <= '0;
`endif
                  end
               end else if (tick_pre == TW'(TICK_DIV - 1)) begin
                  tick_pre <= '0;
                  hold_cnt <= hold_cnt - 16'd1;
               end else begin
                  tick_pre <= tick_pre + 1'b1;
               end
            end
            STOP: begin
`ifdef DRIVE_SEQ_RAMP_EN
               if (fifo_count != '0 && !abort) begin
                  state <= LOAD;
               end else if (speed_0 == '0 && speed_1 == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (ramp_wrap) begin
                  ramp_pre <= '0;
                  speed_0  <= step_toward(speed_0, tgt_0);
                  speed_1  <= step_toward(speed_1, tgt_1);
               end else begin
                  ramp_pre <= ramp_pre + 1'b1;
               end
`else
               speed_0 <= '0;
               speed_1 <= '0;
               if (fifo_count != '0 && !abort) begin
                  state <= LOAD;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
`endif
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_drive_seq.sv
// tb_drive_seq: directed scenarios plus randomized traffic for drive_seq,
// compared every cycle against a timeline model of the sequencer.
module tb_drive_seq;
   localparam int DEPTH    = 4;
   localparam int RAMP_DIV = 4;
   localparam int TICK_DIV = 2;
`ifdef DRIVE_SEQ_RAMP_EN
   localparam bit RAMP_ON = 1'b1;
`else
   localparam bit RAMP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_speed_0;
   logic [5:0]  cmd_speed_1;
   logic [15:0] cmd_hold;
   logic        abort;
   logic [5:0]  speed_0;
   logic [5:0]  speed_1;
   logic        busy;
   logic [2:0]  fifo_count;

   drive_seq #(.DEPTH(DEPTH), .RAMP_DIV(RAMP_DIV), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_speed_0(cmd_speed_0), .cmd_speed_1(cmd_speed_1), .cmd_hold(cmd_hold),
      .abort(abort), .speed_0(speed_0), .speed_1(speed_1), .busy(busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of commands plus a phase with elapsed time;
   // speeds are derived from elapsed time rather than stepped.
   typedef struct {int s0; int s1; int h;} cmd_t;
   cmd_t q[$];
   int m_mode;   // 0 idle, 1 load, 2 slew, 3 dwell, 4 stop
   int m_el;
   int m_s0, m_s1, m_b0, m_b1, m_t0, m_t1, m_hold, m_busy;

   function automatic int moved(int from, int to, int n);
      if (from < to) return (from + n > to) ? to : from + n;
      return (from - n < to) ? to : from - n;
   endfunction

   function automatic int exp_ready();
      return (rst_n && q.size() < DEPTH && !abort) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic enter_stop();
      m_mode = 4; m_el = 0;
      m_b0 = m_s0; m_b1 = m_s1;
      m_t0 = 0; m_t1 = 0;
   endtask

   task automatic model_edge();
      bit   do_push;
      int   qn;
      cmd_t c;
      if (!rst_n) begin
         q.delete();
         m_mode = 0; m_el = 0; m_busy = 0;
         m_s0 = 0; m_s1 = 0; m_t0 = 0; m_t1 = 0;
         return;
      end
      do_push = cmd_valid && (q.size() < DEPTH) && !abort;
      qn = q.size();
      if (abort && (m_mode == 1 || m_mode == 2 || m_mode == 3)) begin
         enter_stop();
      end else begin
         case (m_mode)
            0: if (qn > 0 && !abort) begin m_mode = 1; m_busy = 1; end
            1: begin
               c = q.pop_front();
               m_t0 = c.s0; m_t1 = c.s1; m_hold = c.h;
               m_b0 = m_s0; m_b1 = m_s1;
               m_mode = 2; m_el = 0;
            end
            2: begin
               if (!RAMP_ON) begin
                  m_s0 = m_t0; m_s1 = m_t1; m_mode = 3; m_el = 0;
               end else if (m_s0 == m_t0 && m_s1 == m_t1) begin
                  m_mode = 3; m_el = 0;
               end else begin
                  m_el++;
                  m_s0 = moved(m_b0, m_t0, m_el / RAMP_DIV);
                  m_s1 = moved(m_b1, m_t1, m_el / RAMP_DIV);
               end
            end
            3: begin
               if (m_el == m_hold * TICK_DIV) begin
                  if (qn > 0) m_mode = 1;
                  else enter_stop();
               end else begin
                  m_el++;
               end
            end
            default: begin
               if (!RAMP_ON) begin
                  m_s0 = 0; m_s1 = 0;
                  if (qn > 0 && !abort) m_mode = 1;
                  else begin m_mode = 0; m_busy = 0; end
               end else if (qn > 0 && !abort) begin
                  m_mode = 1;
               end else if (m_s0 == 0 && m_s1 == 0) begin
                  m_mode = 0; m_busy = 0;
               end else begin
                  m_el++;
                  m_s0 = moved(m_b0, 0, m_el / RAMP_DIV);
                  m_s1 = moved(m_b1, 0, m_el / RAMP_DIV);
               end
            end
         endcase
      end
      if (abort) q.delete();
      else if (do_push) q.push_back('{int'(cmd_speed_0), int'(cmd_speed_1), int'(cmd_hold)});
   endtask

   // One clock: check ready mid-cycle, advance the model at the edge, check outputs after.
   task automatic cycle();
      @(negedge clk);
      check("cmd_ready", cmd_ready, exp_ready());
      @(posedge clk);
      model_edge();
      #1;
      check("speed_0", speed_0, m_s0);
      check("speed_1", speed_1, m_s1);
      check("busy", busy, m_busy);
      check("fifo_count", fifo_count, q.size());
   endtask

   task automatic push_cmd(input int s0, input int s1, input int h);
      cmd_valid = 1'b1;
      cmd_speed_0 = 6'(s0); cmd_speed_1 = 6'(s1); cmd_hold = 16'(h);
      cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 1500; i++) begin
         if (m_mode == 0 && q.size() == 0) break;
         cycle();
      end
      check("drain_busy", busy, 0);
      check("drain_speed", speed_0, 0);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
      cmd_speed_0 = '0; cmd_speed_1 = '0; cmd_hold = '0;
      repeat (3) cycle();
      check("rst_ready", cmd_ready, 0);
      check("rst_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      cycle();

      // Single command: jump or slew to 63, hold, stop.
      push_cmd(63, 0, 2);
      cycle(); cycle(); cycle();
      check("single_speed_e3", speed_0, RAMP_ON ? 0 : 63);
      drain();

      push_cmd(10, 5, 3);
      drain();

      // Back-to-back commands with no idle gap.
      push_cmd(8, 8, 1);
      push_cmd(2, 12, 0);
      drain();

      // Fill the queue, then abort with a push pending.
      cmd_valid = 1'b1; cmd_speed_0 = 6'd20; cmd_speed_1 = 6'd20; cmd_hold = 16'd100;
      repeat (8) cycle();
      check("full_count", fifo_count, 4);
      check("full_ready", cmd_ready, 0);
      abort = 1'b1;
      cycle();
      abort = 1'b0; cmd_valid = 1'b0;
      check("abort_count", fifo_count, 0);
      drain();

      // Abort during hold with two commands queued.
      push_cmd(6, 6, 50);
      push_cmd(1, 1, 1);
      push_cmd(2, 2, 2);
      for (int i = 0; i < 200; i++) begin
         if (m_mode == 3) break;
         cycle();
      end
      abort = 1'b1; cmd_valid = 1'b1;
      cycle();
      abort = 1'b0; cmd_valid = 1'b0;
      check("hold_abort_count", fifo_count, 0);
      drain();

      // Reset while active.
      push_cmd(30, 30, 50);
      repeat (30) cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("midrst_speed", speed_0, 0);
      check("midrst_busy", busy, 0);
      check("midrst_count", fifo_count, 0);
      cycle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cmd_valid   = ($urandom_range(0, 3) == 0);
         cmd_speed_0 = 6'($urandom_range(0, 63));
         cmd_speed_1 = 6'($urandom_range(0, 63));
         cmd_hold    = 16'($urandom_range(0, 3));
         abort       = ($urandom_range(0, 199) == 0);
         rst_n       = ($urandom_range(0, 699) != 0);
         cycle();
      end
      cmd_valid = 1'b0; abort = 1'b0; rst_n = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/drive_seq.md
# drive_seq

Command sequencer for the dual-channel PWM motor `drive` block. It buffers timed speed commands (channel 0 and channel 1 speed plus a hold duration) in a small FIFO. It slew-limits the 6-bit speed inputs toward each command's targets and holds them for the commanded time. When the queue runs dry, or on abort, it ramps both channels to a controlled stop. It sits directly upstream of `drive`: its `speed_0`/`speed_1` outputs connect to the `drive` inputs `input_0`/`input_1`.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `RAMP_DIV`, 1000: clock cycles per ±1 speed step.
- `TICK_DIV`, 1000: clock cycles per hold tick.
- `clk`  in  1  system clock; the block uses only this clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on this edge if `cmd_valid` is also high.
- `cmd_speed_0`  in  6  channel 0 target speed, unsigned 0..63.
- `cmd_speed_1`  in  6  channel 1 target speed, unsigned 0..63.
- `cmd_hold`  in  16  hold duration in ticks.
- `abort`  in  1  flush the queue and stop.
- `speed_0`  out  6  drive input 0.
- `speed_1`  out  6  drive input 1.
- `busy`  out  1  state ≠ IDLE.
- `fifo_count`  out  $clog2(DEPTH)+1  queued commands.

## Operation
- **Reset:** while `rst_n`=0 at an edge, the block enters IDLE and forces:
  - `speed_0`/`speed_1` = 0, targets = 0;
  - `fifo_count` = 0, `busy` = 0, all prescalers = 0.
  - `cmd_ready` is 0 while `rst_n` is low.
- **Ready:** `cmd_ready` = (`fifo_count` < DEPTH) && !`abort`, from registered count. A full FIFO never accepts, even when a pop occurs in the same cycle.
- **Push/pop:** push and pop in the same cycle leave the count unchanged. The FIFO is in-order and pointers wrap modulo DEPTH.
- **IDLE:** `busy`=0; speeds hold their value (0). If `fifo_count`>0, go to LOAD.
- **LOAD (1 cycle):**
  - Pop the head entry into `tgt_0`/`tgt_1`/`hold_cnt`.
  - Clear the ramp prescaler.
  - Go to RAMP.
- **RAMP:**
  - The ramp prescaler counts 0..RAMP_DIV-1.
  - On wrap, each channel independently steps by 1 toward its target. A channel already at its target is unchanged.
  - When both speeds equal their targets (evaluated every cycle, including the first), go to HOLD and clear the tick prescaler.
- **HOLD:**
  - The tick prescaler counts 0..TICK_DIV-1; on wrap, `hold_cnt` decrements.
  - When `hold_cnt`==0, exit: to LOAD if `fifo_count`>0, otherwise to STOP.
  - `cmd_hold`=0 exits on the first HOLD cycle.
- **STOP:**
  - Targets are forced to 0 and speeds ramp down as in RAMP.
  - If `fifo_count`>0, go to LOAD; ramping resumes from the current speeds, with no jump.
  - When both speeds are 0, go to IDLE.
- **Abort:**
  - `abort`=1 has priority over everything except reset.
  - FIFO is flushed (count=0, pointers equal); any same-cycle push is refused.
  - The state machine goes to STOP from LOAD/RAMP/HOLD/STOP. From IDLE it stays in IDLE.
  - A held `abort` keeps the block in STOP/IDLE.
- **Arithmetic:** speeds never go below 0 or above 63; the step is exactly 1 and never overshoots the target. `hold_cnt` is 16-bit unsigned and never wraps below 0.

## Timing
- All outputs are registered except `cmd_ready`, which is a combinational function of registered count and `abort`.
- Push accepted at edge E0 → `fifo_count` increments at E0.
  - E1: IDLE→LOAD.
  - E2: pop, LOAD→RAMP.
  - First speed step at E2+RAMP_DIV.
- A ramp of Δ steps takes Δ·RAMP_DIV cycles. HOLD lasts `cmd_hold`·TICK_DIV cycles, plus 1 cycle of exit decision.
- Back-to-back commands: HOLD→LOAD→RAMP with no IDLE gap; speeds are continuous.
- Abort at edge A: `fifo_count`=0 and state=STOP after A; the first down-step occurs RAMP_DIV cycles later.

## Configuration
- `DRIVE_SEQ_RAMP_EN`:
  - Defined: slew-limited RAMP/STOP behaviour as above.
  - Undefined: the ramp prescaler is removed.
    - RAMP loads the speeds to the targets in one cycle, then goes to HOLD.
    - STOP zeroes the speeds in one cycle, then goes to IDLE, or to LOAD if `fifo_count`>0.
  - All other behaviour is unchanged.

## Test plan
All scenarios use DEPTH=4, RAMP_DIV=4, TICK_DIV=2, with `DRIVE_SEQ_RAMP_EN` defined unless stated.

1. **Single command:** reset, push (10,5,hold=3).
   - `speed_0` reaches 10 at push+2+40 cycles; `speed_1` stops at 5 after 20 cycles.
   - Both are held for 6 cycles, then ramp to 0.
   - `busy` falls 40 cycles after the ramp-down starts.
2. **Back-to-back:** push (8,8,1) then (2,12,0). Speeds go 8/8 → 2/12 with no zero dip, then stop; each step is exactly ±1 per 4 cycles.
3. **Full FIFO:** push 5 commands while in RAMP. The 5th sees `cmd_ready`=0, `fifo_count`=4; after the next LOAD, `cmd_ready`=1 and `fifo_count`=3.
4. **Abort mid-hold:** with 2 queued commands, assert `abort` in HOLD at speed 6.
   - Same-cycle push refused; `fifo_count`=0.
   - Speeds reach 0 after 24 cycles, then IDLE.
5. **Reset mid-ramp:** drive `rst_n`=0 for 1 cycle at speed 7 → next cycle speeds 0, count 0, IDLE, `busy`=0.
6. **Macro undefined:** push (63,0,2) → `speed_0`=63 at push+3, held 4 cycles; 0 and IDLE 2 cycles later.
